// File: rtl/ddr_debug_pkg.sv
// Shared widths and defaults for the DDR debug path (event packer and debug stage).
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ddr_debug_pkg;

  localparam int BEAT_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_BEAT = 4;
  localparam int IDX_W          = 2;
  localparam int CNT_W_DEF      = 32;

  localparam logic [WORD_W-1:0] FILL_WORD_DEF = 32'hFFFF_FFFF;

  typedef logic [WORD_W-1:0] word_t;

  // One 128-bit beat; slot k occupies bits [32k+31:32k].
  typedef struct packed {
    word_t [WORDS_PER_BEAT-1:0] slot;
  } beat_t;

  // Overwrite every slot at or above 'used' with the fill word.
  function automatic beat_t pad_beat(input beat_t b, input logic [IDX_W:0] used,
                                     input word_t fill);
    beat_t r;
    r = b;
    for (int k = 0; k < WORDS_PER_BEAT; k++) begin
      if ((IDX_W+1)'(k) >= used) begin
        r.slot[k] = fill;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchroniser for an asynchronous PPS pulse plus registered rising-edge strobe.
// Latency: strobe is high for one cycle, 3 clock edges after the pulse rises.
// Backpressure: none; the strobe is free-running and cannot be stalled.
module pps_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_async,
  output logic strobe
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Synchronise the pulse, keep the previous synchronised value, register the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync1  <= pulse_async;
      sync2  <= sync1;
      sync3  <= sync2;
      strobe <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/ddr_event_packer.sv
// Packs 32-bit event words four per 128-bit AXI-Stream beat; PPS/enable-fall flush pads partial beats.
// Latency: a beat is valid the cycle after its 4th word (or after the flush strobe).
// Backpressure: one beat is held in the output register, one more pending; further words drop and are counted.
module ddr_event_packer
  import ddr_debug_pkg::*;
#(
  parameter logic [WORD_W-1:0] FILL_WORD = FILL_WORD_DEF,
  parameter int                CNT_W     = CNT_W_DEF
) (
  input  logic              clk200_i,
  input  logic              ddr_data_rstn,
  input  logic              pps_i,
  input  logic              enable_i,
  input  logic              event_valid_i,
  input  logic [WORD_W-1:0] event_data_i,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic [CNT_W-1:0]  beat_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             pps_flush;
  logic             en_q;
  logic             en_flush;
  logic             flush;

  beat_t            acc;
  logic [IDX_W-1:0] idx;
  logic             pending;
  beat_t            tdata_q;
  logic             tvalid_q;

  logic             out_free;
  logic             handshake;
  logic             accept;
  logic             drop;
  logic [IDX_W:0]   fill_cnt;
  logic             beat_done;
  beat_t            acc_wr;
  beat_t            beat_padded;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

  pps_sync_edge u_pps_sync (
    .clk         (clk200_i),
    .rst_n       (ddr_data_rstn),
    .pulse_async (pps_i),
    .strobe      (pps_flush)
  );

  // Remember last enable so its falling edge can be turned into a flush strobe.
  always_ff @(posedge clk200_i) begin
    if (!ddr_data_rstn) begin
      en_q <= 1'b0;
    end else begin
      en_q <= enable_i;
    end
  end

  assign en_flush = en_q & ~enable_i;
  assign flush    = pps_flush | en_flush;

  // Output register can take a new beat when empty or being drained this cycle.
  assign out_free  = ~tvalid_q | m_axis_tready;
  assign handshake = tvalid_q & m_axis_tready;

  // A held (pending) beat blocks the accumulator, so new words are dropped.
  assign accept = enable_i & event_valid_i & ~pending;
  assign drop   = enable_i & event_valid_i & pending;

  // Word count after this cycle's accept; 4 means the beat is full.
  assign fill_cnt = {1'b0, idx} + {{IDX_W{1'b0}}, accept};

  // Place the incoming word first so a same-cycle flush pads around it.
  always_comb begin
    acc_wr = acc;
    if (accept) begin
      acc_wr.slot[idx] = event_data_i;
    end
  end

  // A full beat, or a flush with at least one word, closes the beat; never an empty one.
  assign beat_done   = ~pending &
                       ((fill_cnt == 3'(WORDS_PER_BEAT)) | (flush & (fill_cnt != '0)));
  assign beat_padded = pad_beat(acc_wr, fill_cnt, FILL_WORD);

  // Accumulate words, close beats, and move beats into the output register when it is free.
  always_ff @(posedge clk200_i) begin
    if (!ddr_data_rstn) begin
      acc      <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      if (handshake) begin
        tvalid_q <= 1'b0;
      end
      if (beat_done) begin
        idx <= '0;
        if (out_free) begin
          tdata_q  <= beat_padded;
          tvalid_q <= 1'b1;
          acc      <= '0;
        end else begin
          acc     <= beat_padded;
          pending <= 1'b1;
        end
      end else begin
        if (accept) begin
          acc <= acc_wr;
          idx <= fill_cnt[IDX_W-1:0];
        end
        if (pending && out_free) begin
          tdata_q  <= acc;
          tvalid_q <= 1'b1;
          pending  <= 1'b0;
          acc      <= '0;
        end
      end
    end
  end

  // Drop counter saturates; beat counter wraps on every handshake.
  always_ff @(posedge clk200_i) begin
    if (!ddr_data_rstn) begin
      drop_cnt_o <= '0;
      beat_cnt_o <= '0;
    end else begin
      if (drop && (drop_cnt_o != '1)) begin
        drop_cnt_o <= drop_cnt_o + CNT_ONE;
      end
      if (handshake) begin
        beat_cnt_o <= beat_cnt_o + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ddr_event_packer.sv
// Directed self-checking bench for ddr_event_packer.
// Latency: n/a.
// Backpressure: exercised by holding m_axis_tready low.
module tb_ddr_event_packer;

  logic         clk200_i = 1'b0;
  logic         ddr_data_rstn;
  logic         pps_i;
  logic         enable_i;
  logic         event_valid_i;
  logic [31:0]  event_data_i;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [31:0]  drop_cnt_o;
  logic [31:0]  beat_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk200_i = ~clk200_i;

  ddr_event_packer #(
    .FILL_WORD (32'hFFFF_FFFF),
    .CNT_W     (32)
  ) dut (
    .clk200_i      (clk200_i),
    .ddr_data_rstn (ddr_data_rstn),
    .pps_i         (pps_i),
    .enable_i      (enable_i),
    .event_valid_i (event_valid_i),
    .event_data_i  (event_data_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .drop_cnt_o    (drop_cnt_o),
    .beat_cnt_o    (beat_cnt_o)
  );

  task automatic tick();
    @(posedge clk200_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word for exactly one clock edge.
  task automatic send(input logic [31:0] w);
    event_valid_i = 1'b1;
    event_data_i  = w;
    tick();
    event_valid_i = 1'b0;
  endtask

  initial begin
    ddr_data_rstn = 1'b0;
    pps_i         = 1'b0;
    enable_i      = 1'b0;
    event_valid_i = 1'b0;
    event_data_i  = '0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata",  m_axis_tdata,  128'h0);
    chk("rst_drop",   drop_cnt_o,    32'd0);
    chk("rst_beat",   beat_cnt_o,    32'd0);
    ddr_data_rstn = 1'b1;
    enable_i      = 1'b1;
    m_axis_tready = 1'b1;
    tick();

    // Full beat of four words.
    send(32'h11);
    send(32'h22);
    send(32'h33);
    chk("t1_not_early", m_axis_tvalid, 1'b0);
    send(32'h44);
    chk("t1_tvalid", m_axis_tvalid, 1'b1);
    chk("t1_tdata",  m_axis_tdata,  128'h00000044_00000033_00000022_00000011);
    tick();
    chk("t1_tvalid_1cyc", m_axis_tvalid, 1'b0);
    chk("t1_beat_cnt",    beat_cnt_o,    32'd1);

    // PPS flush of a two-word partial beat.
    send(32'hA);
    send(32'hB);
    pps_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_wait_strobe", m_axis_tvalid, 1'b0);
    end
    tick();
    chk("t2_tvalid", m_axis_tvalid, 1'b1);
    chk("t2_tdata",  m_axis_tdata,  128'hFFFFFFFF_FFFFFFFF_0000000B_0000000A);
    tick();
    chk("t2_tvalid_1cyc", m_axis_tvalid, 1'b0);
    chk("t2_beat_cnt",    beat_cnt_o,    32'd2);
    repeat (15) tick();
    pps_i = 1'b0;
    repeat (5) tick();
    pps_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_empty_pps", m_axis_tvalid, 1'b0);
    end
    pps_i = 1'b0;
    repeat (5) tick();
    chk("t2_beat_cnt_after_empty", beat_cnt_o, 32'd2);

    // 4th word lands in the same cycle as the PPS strobe.
    send(32'hC1);
    send(32'hC2);
    send(32'hC3);
    pps_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_wait_strobe", m_axis_tvalid, 1'b0);
    end
    send(32'hC4);
    chk("t4_tvalid", m_axis_tvalid, 1'b1);
    chk("t4_tdata",  m_axis_tdata,  128'h000000C4_000000C3_000000C2_000000C1);
    tick();
    chk("t4_beat_cnt", beat_cnt_o, 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_extra_beat", m_axis_tvalid, 1'b0);
      tick();
    end
    pps_i = 1'b0;
    repeat (5) tick();

    // Enable falling edge flushes a one-word beat; words while disabled are ignored.
    send(32'h55);
    enable_i      = 1'b0;
    event_valid_i = 1'b1;
    event_data_i  = 32'h99;
    tick();
    chk("t5_tvalid", m_axis_tvalid, 1'b1);
    chk("t5_tdata",  m_axis_tdata,  128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000055);
    event_data_i = 32'h9A;
    tick();
    chk("t5_beat_cnt", beat_cnt_o, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_disabled_no_beat", m_axis_tvalid, 1'b0);
    end
    chk("t5_no_drops", drop_cnt_o, 32'd0);
    event_valid_i = 1'b0;
    enable_i      = 1'b1;
    tick();

    // Backpressure: one beat held, one pending, the rest dropped.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      send(32'(i));
      if (i == 4) begin
        chk("t3_first_tvalid", m_axis_tvalid, 1'b1);
        chk("t3_first_tdata",  m_axis_tdata,  {32'd4, 32'd3, 32'd2, 32'd1});
      end
    end
    chk("t3_held_tvalid", m_axis_tvalid, 1'b1);
    chk("t3_held_tdata",  m_axis_tdata,  {32'd4, 32'd3, 32'd2, 32'd1});
    chk("t3_drop_cnt",    drop_cnt_o,    32'd4);
    chk("t3_beat_cnt_0",  beat_cnt_o,    32'd4);
    m_axis_tready = 1'b1;
    tick();
    chk("t3_second_tvalid", m_axis_tvalid, 1'b1);
    chk("t3_second_tdata",  m_axis_tdata,  {32'd8, 32'd7, 32'd6, 32'd5});
    chk("t3_beat_cnt_1",    beat_cnt_o,    32'd5);
    tick();
    chk("t3_drained", m_axis_tvalid, 1'b0);
    chk("t3_beat_cnt_2", beat_cnt_o, 32'd6);
    tick();
    chk("t3_no_dropped_beat", m_axis_tvalid, 1'b0);

    // Reset while a beat is held and another pending.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send(32'h100 + 32'(i));
    end
    chk("t6_pre_tvalid", m_axis_tvalid, 1'b1);
    chk("t6_pre_drop",   drop_cnt_o,    32'd5);
    ddr_data_rstn = 1'b0;
    tick();
    chk("t6_rst_tvalid", m_axis_tvalid, 1'b0);
    chk("t6_rst_tdata",  m_axis_tdata,  128'h0);
    chk("t6_rst_drop",   drop_cnt_o,    32'd0);
    chk("t6_rst_beat",   beat_cnt_o,    32'd0);
    ddr_data_rstn = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_stale_beat", m_axis_tvalid, 1'b0);
    end
    send(32'h201);
    send(32'h202);
    send(32'h203);
    send(32'h204);
    chk("t6_post_tvalid", m_axis_tvalid, 1'b1);
    chk("t6_post_tdata",  m_axis_tdata,  128'h00000204_00000203_00000202_00000201);
    tick();
    chk("t6_post_beat_cnt", beat_cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_event_packer.md
Name: ddr_event_packer

Overview:
- Upstream feeder of the DDR debug stage.
- Packs 32-bit detection event words, four per beat, into 128-bit AXI-Stream beats for the debug stage's s_axis input, which writes them to the AXI virtual FIFO.
- Partial beats are flushed, padded with a fill word, on each PPS rising edge and on enable deassert, so host-side readout stays aligned to seconds.
- Drops events under backpressure and counts them rather than stalling the event source.

Parameters:
FILL_WORD, 32'hFFFF_FFFF, pad value written into unused slots of a flushed beat
CNT_W, 32, width of the drop and beat counters

Ports:
clk200_i  in  1  200 MHz system clock; all logic on rising edge
ddr_data_rstn  in  1  synchronous active-low reset
pps_i  in  1  asynchronous PPS pulse, ≥2 cycles high
enable_i  in  1  packing enable; events ignored while low
event_valid_i  in  1  event word strobe, one word per cycle max
event_data_i  in  32  event word
m_axis_tdata  out  128  packed beat; slot k at [32k+31:32k]
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
drop_cnt_o  out  CNT_W  events lost to backpressure, saturating
beat_cnt_o  out  CNT_W  beats handed over (valid&ready), wrapping

Behaviour:
- Reset (ddr_data_rstn low at a clock edge): m_axis_tvalid=0, m_axis_tdata=0, drop_cnt_o=0, beat_cnt_o=0, slot index=0, accumulator pending=0, PPS sync flops=0. Reset mid-operation discards any partial or pending beat without emitting it.
- PPS sync: two-flop synchroniser, then a rising-edge detect, giving a 1-cycle pps_flush strobe. Latency is 3 cycles from pps_i rise to strobe.
- Enable: a falling edge of enable_i (registered) produces a 1-cycle en_flush strobe. flush = pps_flush | en_flush.
- Data path: accumulator acc[127:0] with slot index idx (0..3), a pending flag, and a single output register (m_axis_tdata/tvalid).
- Output register:
  - Free when tvalid=0 or (tvalid & tready) in this cycle.
  - Loads from the accumulator only when free. tvalid stays asserted with stable tdata until tready.
- Event accept: enable_i & event_valid_i & !pending writes event_data_i to slot idx, then idx increments.
- Event drop: enable_i & event_valid_i & pending increments drop_cnt_o (saturates at all-ones). The word is lost.
- Beat complete: when the accepted word lands in slot 3, or flush occurs with idx>0 (after any same-cycle accept):
  - unused slots are filled with FILL_WORD;
  - if the output register is free, the beat moves to the output at the next edge (tvalid high the cycle after the 4th word); idx resets to 0;
  - otherwise pending=1 holds the beat in acc until the output register is free, then it moves and pending clears.
- Flush with idx=0 and no same-cycle accept is a no-op. An empty beat is never emitted.
- Simultaneous accept + flush: the word is placed first, then padding applies. If the word fills slot 3, the flush adds nothing.
- Flush while pending: the pending beat is already complete; the flush is a no-op.
- beat_cnt_o increments on every valid&ready handshake and wraps modulo 2^CNT_W.
- Throughput: sustained 1 word/cycle with tready=1 gives 1 beat per 4 cycles with no drops.

Decomposition:
- Shared package ddr_debug_pkg holds:
  - BEAT_W=128, WORD_W=32, WORDS_PER_BEAT=4;
  - the default FILL_WORD constant;
  - the CNT_W default.
- The debug stage imports the same package for beat width.
- One natural sub-module, pps_sync_edge: two-flop synchroniser plus rising-edge strobe, reusable by the debug stage's pps_i handling.

Test Plan:
1. Reset, enable=1, tready=1, words 0x11,0x22,0x33,0x44 on consecutive cycles -> one beat tdata=0x00000044_00000033_00000022_00000011, tvalid for 1 cycle starting the cycle after 0x44, beat_cnt_o=1.
2. Two words 0xA,0xB, then pps_i high for 20 cycles -> 3 cycles after the pps rise a beat 0xFFFFFFFF_FFFFFFFF_0000000B_0000000A is emitted. A second PPS with idx=0 emits nothing.
3. tready=0, continuous words 1..12 -> beat{1..4} held stable in output, beat{5..8} pending, words 9..12 dropped, drop_cnt_o=4. Raising tready delivers the two beats in order, beat_cnt_o=2.
4. Word arrives in the same cycle as pps_flush, with idx=3 beforehand -> beat holds 4 real words, no padding, and no extra empty beat follows.
5. enable_i falls with idx=1 (word 0x55) -> beat 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_00000055. Words while enable=0 are ignored and not counted as drops.
6. ddr_data_rstn low for one cycle while tvalid=1 and pending=1 -> tvalid=0 next cycle, counters=0, and no stale beat after reset release.
